// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit: access sizes, FSM states,
// little-endian lane extraction with extension, and sub-word merge for read-modify-write.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StStore,
    StResp
  } state_t;

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = sext ? {{24{b[7]}}, b} : {24'b0, b};
      SZ_HALF: res = sext ? {{16{h[15]}}, h} : {16'b0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: res[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: load data extract/extend and store data merge into a read word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  always_comb begin
    load_o  = lane_extract(rdata_i, off_i, size_i, signed_i);
    merge_o = lane_merge(rdata_i, wdata_i, off_i, size_i);
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between datapath and a word-wide dmem; sub-word stores use
// read-modify-write, one request in flight, completion signalled by a resp_valid pulse.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] memReadData
);

  state_t      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        req_err_d;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    req_err_d = (req_size == 2'd3) ||
                ((req_size == SZ_HALF) && req_addr[0]) ||
                ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                ({2'b00, req_addr[31:2]} >= MEM_WORDS);
  end

  lsu_lane u_lane (
    .rdata_i  (memReadData),
    .wdata_i  (wdata_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'b0;
      mem_addr_q   <= 32'b0;
      mem_wdata_q  <= 32'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q     <= req_write;
            size_q      <= req_size;
            signed_q    <= req_signed;
            off_q       <= req_addr[1:0];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (req_err_d) begin
              // Errors never touch dmem; memAddr keeps its last value.
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'b0;
            end else begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
              if (!req_write) begin
                state_q <= StLoad;
              end else if (req_size == SZ_WORD) begin
                state_q     <= StStore;
                mem_wdata_q <= req_wdata;
              end else begin
                state_q <= StRmwRd;
              end
            end
          end
        end
        StLoad: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_data;
        end
        StRmwRd: begin
          state_q     <= StStore;
          mem_wdata_q <= merge_data;
        end
        StStore: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'b0;
        end
        StResp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Strobes gated by reset so an aborted operation can never write dmem.
  always_comb begin
    MemRead  = !reset && ((state_q == StLoad) || (state_q == StRmwRd));
    MemWrite = !reset && (state_q == StStore) && write_q;
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign memAddr      = mem_addr_q;
  assign memWriteData = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu paired with a combinational-read dmem; a transaction-level model
// predicts each response, its cycle and dmem strobes, and checks outputs every cycle.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] memReadData;

  always #5 clk = ~clk;

  dmem_lsu #(.MEM_WORDS(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .memReadData  (memReadData)
  );

  // dmem: combinational read, write at posedge; bench pokes share the write port.
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = 10'd0;
  logic [31:0] poke_val = 32'h0;

  assign memReadData = mem[memAddr[11:2]];

  always @(posedge clk) begin
    if (MemWrite) mem[memAddr[11:2]] <= memWriteData;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
  } txn_t;

  txn_t q[$];
  int   ncyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
           ((a >> 2) >= 32'd1024);
  endfunction

  function automatic int latency(input txn_t t);
    if (is_err(t.sz, t.addr)) return 1;
    if (!t.wr || t.sz == 2'd2) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input int off);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input int off);
    logic [31:0] mask;
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  // Model/compare process: runs on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    txn_t        t;
    logic [31:0] exp_rd;
    int          idx;
    ncyc++;
    if (poke_en) ref_mem[poke_idx] = poke_val;
    if (reset) begin
      chk("reset_memwrite", {31'b0, MemWrite}, 32'd0);
      chk("reset_memread", {31'b0, MemRead}, 32'd0);
      q.delete();
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, (q.size() == 0)});
      if (q.size() != 0) begin
        t = q[0];
        rd_cnt += int'(MemRead);
        wr_cnt += int'(MemWrite);
        if (MemRead || MemWrite) chk("mem_addr", memAddr, t.addr & 32'hFFFF_FFFC);
        if (t.due == ncyc) begin
          idx = int'(t.addr[11:2]);
          chk("resp_valid_due", {31'b0, resp_valid}, 32'd1);
          if (is_err(t.sz, t.addr)) begin
            chk("resp_err", {31'b0, resp_err}, 32'd1);
            chk("resp_rdata_err", resp_rdata, 32'd0);
            chk("rd_cnt_err", rd_cnt, 0);
            chk("wr_cnt_err", wr_cnt, 0);
          end else if (!t.wr) begin
            exp_rd = exp_load(ref_mem[idx], t.sz, t.sg, int'(t.addr[1:0]));
            chk("resp_err_ld", {31'b0, resp_err}, 32'd0);
            chk("resp_rdata_ld", resp_rdata, exp_rd);
            chk("rd_cnt_ld", rd_cnt, 1);
            chk("wr_cnt_ld", wr_cnt, 0);
          end else begin
            ref_mem[idx] = exp_store(ref_mem[idx], t.wd, t.sz, int'(t.addr[1:0]));
            chk("resp_err_st", {31'b0, resp_err}, 32'd0);
            chk("resp_rdata_st", resp_rdata, 32'd0);
            chk("rd_cnt_st", rd_cnt, (t.sz == 2'd2) ? 0 : 1);
            chk("wr_cnt_st", wr_cnt, 1);
          end
          chk("mem_word", mem[idx], ref_mem[idx]);
          void'(q.pop_front());
          rd_cnt = 0;
          wr_cnt = 0;
        end else begin
          chk("resp_valid_early", {31'b0, resp_valid}, 32'd0);
        end
      end else begin
        chk("resp_valid_idle", {31'b0, resp_valid}, 32'd0);
        chk("memread_idle", {31'b0, MemRead}, 32'd0);
        chk("memwrite_idle", {31'b0, MemWrite}, 32'd0);
      end
      if (req_valid && req_ready) begin
        t.wr   = req_write;
        t.sz   = req_size;
        t.sg   = req_signed;
        t.addr = req_addr;
        t.wd   = req_wdata;
        t.due  = ncyc + latency(t);
        q.push_back(t);
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    poke_idx = idx[9:0];
    poke_val = val;
    poke_en  = 1'b1;
    @(posedge clk);
    #2 poke_en = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic rdy;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #2;
      if (rdy) return;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: request at %08h never accepted", addr);
  endtask

  task automatic finish_req(output logic [31:0] rdata, output logic err);
    req_valid = 1'b0;
    rdata = 32'hX;
    err   = 1'bX;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk);
        #2;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL resp_timeout: no resp_valid within bound");
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err);
    issue(wr, sz, sg, addr, wd);
    finish_req(rdata, err);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", memAddr, 32'd0);
    chk("rst_mem_wdata", memWriteData, 32'd0);
    reset = 1'b0;

    // Word store then word load.
    poke(4, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("lit_word_load", rd, 32'hDEAD_BEEF);

    // Byte RMW store.
    poke(4, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA, rd, er);
    chk("lit_byte_rmw", mem[4], 32'h1122_AA44);

    // Sub-word loads with extension.
    poke(4, 32'h80FF_7F01);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, rd, er);
    chk("lit_sbyte", rd, 32'hFFFF_FFFF);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er);
    chk("lit_uhalf", rd, 32'h0000_80FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er);
    chk("lit_shalf", rd, 32'hFFFF_80FF);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er);
    chk("lit_ubyte_top", rd, 32'h0000_0080);
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, rd, er);
    do_req(1'b1, 2'd1, 1'b0, 32'h10, 32'h1234_5678, rd, er);
    chk("lit_half_rmw", mem[4], 32'h80FF_5678);

    // Error cases.
    do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, rd, er);
    chk("lit_err_half", {31'b0, er}, 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h02, 32'h5555_5555, rd, er);
    chk("lit_err_word", {31'b0, er}, 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, er);
    chk("lit_err_size", {31'b0, er}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd, er);
    chk("lit_err_range", {31'b0, er}, 32'd1);
    poke(1023, 32'h0BAD_CAFE);
    do_req(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, rd, er);
    chk("lit_last_word", rd, 32'h0BAD_CAFE);

    // Reset while in STORE abandons the write.
    poke(4, 32'hCAFE_F00D);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("lit_reset_nowrite", mem[4], 32'hCAFE_F00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("lit_after_reset", rd, 32'hCAFE_F00D);

    // Back-to-back with req_valid held high.
    poke(5, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h14, 32'h0000_0055);
    issue(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    finish_req(rd, er);
    chk("lit_b2b_load", rd, 32'hBEEF_0055);
    repeat (4) @(posedge clk);
    #2;
    chk("pending_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
